mem_mod_mp: RTL and testbench
=============================

Name: mem_mod_mp

Overview:
Parametrised successor to the team's single-port-pair memory. It has one write port with byte enables and RD_PORTS independent read ports with registered, valid-qualified reads. A selectable read-during-write policy, and a post-reset hardware clear sequence that initialises every word to INIT_VALUE. It serves as general scratch or register-file storage inside datapath blocks.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of BYTE_W
BYTE_W, 8, bits per write-enable lane
DEPTH, 16, number of words; need not be a power of two
ADDR_WIDTH, $clog2(DEPTH) (min 1), address width
RD_PORTS, 2, number of read ports (>=1)
RDW_MODE, 0, same-address read/write in one cycle: 0 = read-first (old data), 1 = write-first (new data, merged per byte lane)
INIT_VALUE, 0, word value written to every location after reset

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_be  in  DATA_WIDTH/BYTE_W  byte-lane enables; lane i covers bits [i*BYTE_W +: BYTE_W]
wr_data  in  DATA_WIDTH  write data
rd_en  in  RD_PORTS  per-port read request
rd_addr  in  RD_PORTS*ADDR_WIDTH  port p address at [p*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  RD_PORTS*DATA_WIDTH  port p data at [p*DATA_WIDTH +: DATA_WIDTH]; registered
rd_valid  out  RD_PORTS  port p data valid; one-cycle pulse per accepted read
rd_err  out  RD_PORTS  port p out-of-range read flag; qualified by rd_valid
wr_err  out  1  one-cycle pulse: accepted write had wr_addr >= DEPTH
busy  out  1  high while the clear sequence runs; requests are ignored

Behaviour:
- Reset (async assert): state=INIT, clear counter=0, busy=1, rd_data=0, rd_valid=0, rd_err=0, wr_err=0. Memory contents are not reset directly.
- INIT state:
  - Each cycle writes INIT_VALUE to mem[counter], then counter increments.
  - After writing index DEPTH-1, the next state is READY and busy falls; busy is high for exactly DEPTH cycles after rst deasserts.
  - wr_en and rd_en are ignored: no memory change, rd_valid=0, wr_err=0.
  - rst re-asserted mid-INIT restarts the sequence from index 0.
- READY state: stays in READY until rst.
- Write (READY, wr_en=1):
  - wr_addr < DEPTH: at the edge, for each lane with wr_be[i]=1, mem[wr_addr] lane i <= wr_data lane i; other lanes keep their value. wr_be all zero leaves the word unchanged (no error).
  - wr_addr >= DEPTH: memory unchanged; wr_err=1 in the following cycle for one cycle.
- Read (READY, rd_en[p]=1):
  - Latency is 1 cycle: the edge that samples the request updates rd_data[p], and rd_valid[p]=1 for that following cycle.
  - rd_addr[p] >= DEPTH: rd_data[p]=0 and rd_err[p]=1 alongside rd_valid[p].
  - rd_en[p]=0: rd_valid[p]=0, rd_err[p]=0, and rd_data[p] holds its last value.
- Ports are fully independent. Any number of ports may read the same address in the same cycle, and all return identical data.
- Same-cycle read and write to the same valid address:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the merged word (enabled lanes from wr_data, others from the old word).
- Reset mid-operation: in-flight read results are discarded (rd_valid=0), and the memory is re-cleared by INIT.
- Address width: addresses are compared against DEPTH at full ADDR_WIDTH; no wrap-around or truncation.

Test Plan:
- Reset, then DEPTH=16 with INIT_VALUE=8'hA5 → busy high for exactly 16 cycles; then read all addresses on port 0 → every rd_data=8'hA5, with rd_valid one cycle after each rd_en.
- Assert rd_en and wr_en on cycle 3 of INIT → no memory change, rd_valid stays 0; re-assert rst at cycle 8 → busy lasts another full 16 cycles from release.
- DATA_WIDTH=16: write 16'h1234 with be=2'b11, then 16'hABCD with be=2'b10 to addr 5 → read returns 16'hAB34.
- Same cycle: write 8'h77 to addr 2 (old value 8'h11) and read addr 2 on both ports → RDW_MODE=0 gives 8'h11 on both ports, RDW_MODE=1 gives 8'h77 on both.
- DEPTH=12: write to addr 13 → wr_err pulses for 1 cycle and no location changes; read addr 12 → rd_data=0 with rd_err=1 and rd_valid=1.
- Port 0 reads addr 4 while port 1 reads addr 9 in the same cycle → each port returns its own word; a following idle cycle gives rd_valid=0 with rd_data held.

Source files
------------

// File: rtl/mem_mod_mp_if.sv
// mem_mod_mp_if: bundles the write port, the read ports and the status outputs of mem_mod_mp.
//   master modport: requester side. It drives the write/read requests and observes the results.
//   slave modport : memory side. It accepts the requests and drives rd_data/rd_valid/rd_err/wr_err/busy.
// rd_addr and rd_data are flattened per port: port p uses slice [p*W +: W].
interface mem_mod_mp_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BYTE_W     = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RD_PORTS   = 2
);
    logic                             wr_en;
    logic [ADDR_WIDTH-1:0]            wr_addr;
    logic [DATA_WIDTH/BYTE_W-1:0]     wr_be;
    logic [DATA_WIDTH-1:0]            wr_data;
    logic [RD_PORTS-1:0]              rd_en;
    logic [RD_PORTS*ADDR_WIDTH-1:0]   rd_addr;
    logic [RD_PORTS*DATA_WIDTH-1:0]   rd_data;
    logic [RD_PORTS-1:0]              rd_valid;
    logic [RD_PORTS-1:0]              rd_err;
    logic                             wr_err;
    logic                             busy;

    modport master (
        output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, rd_err, wr_err, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, rd_err, wr_err, busy
    );
endinterface

// File: rtl/mem_mod_mp.sv
// mem_mod_mp: scratch/register-file memory with one byte-enabled write port and RD_PORTS
// independent registered read ports. After reset a clear sequence writes INIT_VALUE to every
// word. busy is high while it runs and all requests are ignored during that time.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset. It restarts the clear sequence.
//   bus : mem_mod_mp_if.slave. It carries the write request, the per-port read requests,
//         rd_data/rd_valid/rd_err, wr_err and busy.
// RDW_MODE selects what a read returns when the same cycle writes the same word:
// 0 returns the old word, 1 returns the word after the byte-lane merge.
module mem_mod_mp #(
    parameter int unsigned          DATA_WIDTH = 8,
    parameter int unsigned          BYTE_W     = 8,
    parameter int unsigned          DEPTH      = 16,
    parameter int unsigned          ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned          RD_PORTS   = 2,
    parameter int unsigned          RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst,
    mem_mod_mp_if.slave  bus
);
    localparam int unsigned NUM_LANES = DATA_WIDTH / BYTE_W;
    // One extra bit so that DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {StInit, StReady} state_t;

    state_t                         state_q;
    logic [ADDR_WIDTH-1:0]          cnt_q;
    logic                           busy_q;
    logic [RD_PORTS*DATA_WIDTH-1:0] rd_data_q;
    logic [RD_PORTS-1:0]            rd_valid_q;
    logic [RD_PORTS-1:0]            rd_err_q;
    logic                           wr_err_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready;
    logic                  wr_in_range;
    logic                  wr_fire;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    logic [ADDR_WIDTH-1:0] rd_addr_p   [RD_PORTS];
    logic [RD_PORTS-1:0]   rd_in_range;
    logic [DATA_WIDTH-1:0] rd_word     [RD_PORTS];

    assign ready       = (state_q == StReady);
    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);
    assign wr_fire     = ready && bus.wr_en && wr_in_range;

    // The write is a read-modify-write of the whole word. The same merged word also feeds
    // write-first reads.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{bus.wr_be[i]}};
        end
        wr_old    = wr_in_range ? mem[bus.wr_addr] : '0;
        wr_merged = (wr_old & ~lane_mask) | (bus.wr_data & lane_mask);
    end

    // The clear sequence owns the single memory write port while it runs.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = bus.wr_addr;
        mem_wd = wr_merged;
        if (state_q == StInit) begin
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = INIT_VALUE;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_addr_p[p]   = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            rd_in_range[p] = ({1'b0, rd_addr_p[p]} < DEPTH_W);
            rd_word[p]     = '0;
            if (rd_in_range[p]) begin
                if ((RDW_MODE == 1) && wr_fire && (rd_addr_p[p] == bus.wr_addr)) begin
                    rd_word[p] = wr_merged;
                end else begin
                    rd_word[p] = mem[rd_addr_p[p]];
                end
            end
        end
    end

    // Control FSM with all outputs registered. The rd_valid/rd_err/wr_err pulses default low
    // each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            rd_err_q   <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= '0;
            rd_err_q   <= '0;
            wr_err_q   <= 1'b0;
            unique case (state_q)
                StInit: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= StReady;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    end
                end
                StReady: begin
                    wr_err_q <= bus.wr_en && !wr_in_range;
                    for (int p = 0; p < RD_PORTS; p++) begin
                        if (bus.rd_en[p]) begin
                            rd_valid_q[p]                        <= 1'b1;
                            rd_err_q[p]                          <= !rd_in_range[p];
                            rd_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_word[p];
                        end
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.wr_err   = wr_err_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mem_mod_mp.sv
// Scoreboard bench for mem_mod_mp. Two instances (read-first and write-first) receive
// identical stimulus. A plain array model predicts the read results, which are queued with
// their due cycle. A negedge monitor pops and compares them whenever rd_valid is seen, and it
// checks busy, wr_err and held rd_data on every cycle.
module tb_mem_mod_mp;
    localparam int unsigned DW    = 16;
    localparam int unsigned BW    = 8;
    localparam int unsigned DEPTH = 12;
    localparam int unsigned AW    = 4;
    localparam int unsigned RP    = 2;
    localparam int unsigned NL    = DW / BW;
    localparam int unsigned NQ    = 2 * RP;
    localparam logic [DW-1:0] INIT = 16'hA5C3;

    typedef struct {
        int          due;
        logic [DW-1:0] data;
        logic        err;
    } rd_exp_t;

    logic clk;
    logic rst;

    mem_mod_mp_if #(.DATA_WIDTH(DW), .BYTE_W(BW), .ADDR_WIDTH(AW), .RD_PORTS(RP)) if0 ();
    mem_mod_mp_if #(.DATA_WIDTH(DW), .BYTE_W(BW), .ADDR_WIDTH(AW), .RD_PORTS(RP)) if1 ();

    mem_mod_mp #(
        .DATA_WIDTH(DW), .BYTE_W(BW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_PORTS(RP),
        .RDW_MODE(0), .INIT_VALUE(INIT)
    ) dut0 (.clk(clk), .rst(rst), .bus(if0));

    mem_mod_mp #(
        .DATA_WIDTH(DW), .BYTE_W(BW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_PORTS(RP),
        .RDW_MODE(1), .INIT_VALUE(INIT)
    ) dut1 (.clk(clk), .rst(rst), .bus(if1));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int edges   = 0;

    logic [DW-1:0] model [DEPTH];
    rd_exp_t       exp_q [NQ][$];
    int            werr_q [$];
    logic [DW-1:0] last_data [NQ];
    logic          done       = 1'b0;
    logic          final_done = 1'b0;

    logic [RP*DW-1:0] obs_data  [2];
    logic [RP-1:0]    obs_valid [2];
    logic [RP-1:0]    obs_err   [2];
    logic             obs_werr  [2];
    logic             obs_busy  [2];

    assign obs_data[0]  = if0.rd_data;
    assign obs_data[1]  = if1.rd_data;
    assign obs_valid[0] = if0.rd_valid;
    assign obs_valid[1] = if1.rd_valid;
    assign obs_err[0]   = if0.rd_err;
    assign obs_err[1]   = if1.rd_err;
    assign obs_werr[0]  = if0.wr_err;
    assign obs_werr[1]  = if1.wr_err;
    assign obs_busy[0]  = if0.busy;
    assign obs_busy[1]  = if1.busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Clock edges seen since rst was last released.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor process
    always @(negedge clk) begin
        rd_exp_t e;
        int      d;
        int      p;
        logic    exp_werr;
        if (rst) begin
            for (int q = 0; q < NQ; q++) begin
                exp_q[q].delete();
                last_data[q] = '0;
            end
            werr_q.delete();
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rst_valid[d%0d]", k), 32'(obs_valid[k]), 32'd0);
                chk($sformatf("rst_busy[d%0d]", k), 32'(obs_busy[k]), 32'd1);
            end
        end else begin
            exp_werr = 1'b0;
            if (werr_q.size() > 0 && werr_q[0] <= cyc) begin
                exp_werr = 1'b1;
                void'(werr_q.pop_front());
            end
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy[d%0d]", k), 32'(obs_busy[k]), 32'(edges < DEPTH));
                chk($sformatf("wr_err[d%0d]", k), 32'(obs_werr[k]), 32'(exp_werr));
            end
            for (int q = 0; q < NQ; q++) begin
                d = q / RP;
                p = q % RP;
                while (exp_q[q].size() > 0 && exp_q[q][0].due < cyc) begin
                    e = exp_q[q].pop_front();
                    chk($sformatf("rd_missing[d%0d p%0d]", d, p), 32'(cyc), 32'(e.due));
                end
                if (obs_valid[d][p]) begin
                    if (exp_q[q].size() == 0) begin
                        chk($sformatf("rd_unexpected[d%0d p%0d]", d, p),
                            32'(obs_valid[d][p]), 32'd0);
                    end else begin
                        e = exp_q[q].pop_front();
                        chk($sformatf("rd_due[d%0d p%0d]", d, p), 32'(cyc), 32'(e.due));
                        chk($sformatf("rd_data[d%0d p%0d]", d, p),
                            32'(obs_data[d][p*DW +: DW]), 32'(e.data));
                        chk($sformatf("rd_err[d%0d p%0d]", d, p), 32'(obs_err[d][p]),
                            32'(e.err));
                        last_data[q] = e.data;
                    end
                end else begin
                    chk($sformatf("rd_hold[d%0d p%0d]", d, p),
                        32'(obs_data[d][p*DW +: DW]), 32'(last_data[q]));
                    chk($sformatf("rd_err_idle[d%0d p%0d]", d, p), 32'(obs_err[d][p]), 32'd0);
                end
            end
            if (done && !final_done) begin
                for (int q = 0; q < NQ; q++) begin
                    chk($sformatf("rd_leftover[q%0d]", q), 32'(exp_q[q].size()), 32'd0);
                end
                chk("wr_err_leftover", 32'(werr_q.size()), 32'd0);
                final_done = 1'b1;
            end
        end
    end

    // Drives one request cycle and predicts its outcome from the model. It returns 1 time unit
    // after the sampling edge.
    task automatic issue(input logic wen, input logic [AW-1:0] wa, input logic [NL-1:0] be,
                         input logic [DW-1:0] wd, input logic [RP-1:0] ren,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        logic          wr_ok;
        logic [DW-1:0] merged;
        logic [AW-1:0] a;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          er;
        if0.wr_en = wen;  if0.wr_addr = wa; if0.wr_be = be; if0.wr_data = wd;
        if0.rd_en = ren;  if0.rd_addr = {ra1, ra0};
        if1.wr_en = wen;  if1.wr_addr = wa; if1.wr_be = be; if1.wr_data = wd;
        if1.rd_en = ren;  if1.rd_addr = {ra1, ra0};
        if (!rst && edges >= DEPTH) begin
            wr_ok  = wen && (int'(wa) < DEPTH);
            merged = '0;
            if (wr_ok) begin
                merged = model[wa];
                for (int i = 0; i < NL; i++) begin
                    if (be[i]) merged[i*BW +: BW] = wd[i*BW +: BW];
                end
            end
            for (int p = 0; p < RP; p++) begin
                a = (p == 0) ? ra0 : ra1;
                if (ren[p]) begin
                    if (int'(a) < DEPTH) begin
                        d0 = model[a];
                        d1 = (wr_ok && a == wa) ? merged : model[a];
                        er = 1'b0;
                    end else begin
                        d0 = '0;
                        d1 = '0;
                        er = 1'b1;
                    end
                    exp_q[p].push_back('{due: cyc + 1, data: d0, err: er});
                    exp_q[RP + p].push_back('{due: cyc + 1, data: d1, err: er});
                end
            end
            if (wr_ok) model[wa] = merged;
            if (wen && int'(wa) >= DEPTH) werr_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = INIT;
        idle(hold);
        rst = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            issue(1'b0, '0, '0, '0, 2'b11, AW'(a), AW'(15 - a));
        end
    endtask

    // Stimulus process
    initial begin
        logic [AW-1:0]  wa;
        logic [AW-1:0]  ra0;
        logic [AW-1:0]  ra1;
        logic [NL-1:0]  be;
        logic [DW-1:0]  wd;
        logic [RP-1:0]  ren;
        logic           wen;
        rst = 1'b1;
        if0.wr_en = 1'b0; if0.wr_addr = '0; if0.wr_be = '0; if0.wr_data = '0;
        if0.rd_en = '0;   if0.rd_addr = '0;
        if1.wr_en = 1'b0; if1.wr_addr = '0; if1.wr_be = '0; if1.wr_data = '0;
        if1.rd_en = '0;   if1.rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = INIT;
        @(posedge clk);
        #1;
        do_reset(3);

        // Requests during the clear sequence are ignored. rst is re-asserted mid-sequence.
        idle(2);
        issue(1'b1, 4'd3, 2'b11, 16'hDEAD, 2'b11, 4'd3, 4'd0);
        idle(4);
        do_reset(2);
        idle(DEPTH);
        read_all();

        // Byte-lane merge
        issue(1'b1, 4'd5, 2'b11, 16'h1234, 2'b00, '0, '0);
        issue(1'b1, 4'd5, 2'b10, 16'hABCD, 2'b00, '0, '0);
        issue(1'b0, '0, '0, '0, 2'b01, 4'd5, 4'd0);
        issue(1'b1, 4'd5, 2'b00, 16'hFFFF, 2'b10, 4'd0, 4'd5);

        // Same-address read during write: full-word and single-lane
        issue(1'b1, 4'd2, 2'b11, 16'h0011, 2'b00, '0, '0);
        issue(1'b1, 4'd2, 2'b11, 16'h0077, 2'b11, 4'd2, 4'd2);
        issue(1'b1, 4'd2, 2'b01, 16'h9955, 2'b11, 4'd2, 4'd2);
        issue(1'b0, '0, '0, '0, 2'b11, 4'd2, 4'd2);

        // Out-of-range write and read
        issue(1'b1, 4'd13, 2'b11, 16'hBEEF, 2'b00, '0, '0);
        issue(1'b0, '0, '0, '0, 2'b11, 4'd12, 4'd15);
        idle(1);
        read_all();

        // Independent ports, then an idle cycle with data held
        issue(1'b1, 4'd4, 2'b11, 16'h4444, 2'b00, '0, '0);
        issue(1'b1, 4'd9, 2'b11, 16'h9999, 2'b00, '0, '0);
        issue(1'b0, '0, '0, '0, 2'b11, 4'd4, 4'd9);
        idle(2);

        // Randomized traffic biased toward write/read address collisions
        for (int k = 0; k < 400; k++) begin
            wen = 1'($urandom_range(0, 1));
            wa  = AW'($urandom_range(0, 15));
            be  = NL'($urandom_range(0, 3));
            wd  = DW'($urandom());
            ren = RP'($urandom_range(0, 3));
            ra0 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 15));
            ra1 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 15));
            issue(wen, wa, be, wd, ren, ra0, ra1);
        end
        idle(1);
        read_all();

        // An in-flight read is discarded by reset, and the memory is cleared again
        issue(1'b1, 4'd7, 2'b11, 16'h7777, 2'b00, '0, '0);
        issue(1'b0, '0, '0, '0, 2'b11, 4'd7, 4'd7);
        do_reset(2);
        idle(DEPTH);
        read_all();
        idle(2);

        done = 1'b1;
        for (int i = 0; i < 10 && !final_done; i++) begin
            @(posedge clk);
            #1;
        end
        #20;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
